// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared constants and state type for the A2D SPI responder
package a2d_pkg;

  localparam int FRAME_BITS = 16;
  localparam int NUM_CH     = 8;
  localparam int CH_W       = 3;
  localparam int RES_W      = 12;
  localparam int CH_MSB     = 13;
  localparam int CH_LSB     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/a2d_spi_resp_sync_edge.sv
// rtl/a2d_spi_resp_sync_edge.sv - 2-flop synchronizer with rise/fall event pulses
module sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two stages to settle metastability, a third to hold history for edge detect.
  // Reset to the pin's idle level so release of reset never fakes an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/a2d_spi_resp.sv
// rtl/a2d_spi_resp.sv - SPI responder modelling an 8-channel 12-bit A2D converter
module a2d_spi_resp #(
  parameter int FRAME_BITS = a2d_pkg::FRAME_BITS,
  parameter int NUM_CH     = a2d_pkg::NUM_CH
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ss_n,
  input  logic                      i_sclk,
  input  logic                      i_mosi,
  output logic                      o_miso,
  input  logic                      i_wr_en,
  input  logic [a2d_pkg::CH_W-1:0]  i_wr_chnnl,
  input  logic [a2d_pkg::RES_W-1:0] i_wr_data,
  output logic [a2d_pkg::CH_W-1:0]  o_cmd_chnnl,
  output logic                      o_frame_done
);

  import a2d_pkg::*;

  localparam int                 CNT_W     = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]   C_LAST    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]   C_LAST_M1 = CNT_W'(FRAME_BITS - 1);

  logic                  w_sclk_rise;
  logic                  w_sclk_fall;
  logic                  w_ss_rise;
  logic                  w_ss_fall;
  logic [FRAME_BITS-1:0] w_load;

  logic                  r_mosi_meta;
  logic                  r_mosi_sync;
  logic [RES_W-1:0]      r_regs [NUM_CH];
  state_t                r_state;
  logic [FRAME_BITS-1:0] r_tx;
  logic [CH_MSB:0]       r_rx;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CH_W-1:0]       r_cmd_chnnl;
  logic                  r_frame_done;

  sync_edge #(.RESET_VAL(1'b1)) u_sync_sclk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_sclk),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_ss_n),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  // MOSI needs only alignment with the synchronized SCLK, not edge events.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= i_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // Host-side channel value store; writes land on the next clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_regs[i_wr_chnnl] <= i_wr_data;
    end
  end

  // Response word: zero-padded value of the channel named by the previous frame.
  always_comb begin
    w_load = '0;
    w_load[RES_W-1:0] = r_regs[r_cmd_chnnl];
  end

  // Frame sequencing: snapshot on select, shift on SCLK, commit channel on deselect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_tx         <= '0;
      r_rx         <= '0;
      r_bit_cnt    <= '0;
      r_cmd_chnnl  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_tx      <= w_load;
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_ss_rise) begin
            // Deselect before the last bit: drop the frame, keep the old channel.
            r_state <= IDLE;
          end else begin
            if (w_sclk_rise) begin
              r_rx      <= {r_rx[CH_MSB-1:0], r_mosi_sync};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == C_LAST_M1) begin
                r_state <= DONE;
              end
            end
            // The first falling edge precedes any sample, so bit 15 stays put.
            if (w_sclk_fall && (r_bit_cnt != '0) && (r_bit_cnt < C_LAST)) begin
              r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (w_ss_rise) begin
            r_cmd_chnnl  <= r_rx[CH_MSB:CH_LSB];
            r_frame_done <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_miso       = (r_state != IDLE) & r_tx[FRAME_BITS-1];
  assign o_cmd_chnnl  = r_cmd_chnnl;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb/tb_a2d_spi_resp.sv - self-checking bench for a2d_spi_resp
module tb_a2d_spi_resp;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n = 1'b1;
  logic        sclk = 1'b1;
  logic        mosi = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_ch = 3'd0;
  logic [11:0] wr_data = 12'h000;
  logic        miso;
  logic [2:0]  cmd;
  logic        fd;

  int checks = 0;
  int failures = 0;
  int fd_seen = 0;
  int fd_exp = 0;

  logic [11:0] m_regs [8];
  logic [2:0]  m_cmd;

  typedef struct {
    logic [2:0]  ch;
    logic        pre_wr;
    logic [2:0]  wch;
    logic [11:0] wval;
    logic [15:0] exp_word;
  } vec_t;
  vec_t tbl [10];

  a2d_spi_resp dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ss_n       (ss_n),
    .i_sclk       (sclk),
    .i_mosi       (mosi),
    .o_miso       (miso),
    .i_wr_en      (wr_en),
    .i_wr_chnnl   (wr_ch),
    .i_wr_data    (wr_data),
    .o_cmd_chnnl  (cmd),
    .o_frame_done (fd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fd === 1'b1) fd_seen++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic hwrite(input logic [2:0] ch, input logic [11:0] val);
    @(posedge clk);
    #1 wr_en = 1'b1; wr_ch = ch; wr_data = val;
    @(posedge clk);
    #1 wr_en = 1'b0;
    m_regs[ch] = val;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 12'h000;
    m_cmd = 3'd0;
  endtask

  // One SPI frame; mid_at<0 means no write during the frame.
  task automatic frame(input logic [2:0] ch, input int nrise, input int mid_at,
                       input logic [2:0] wch, input logic [11:0] wval,
                       input bit snap_wr, output logic [15:0] got);
    logic [15:0] word;
    logic [15:0] exp;
    logic [4:0]  fdv;
    bit          complete;
    word = {2'b00, ch, 11'($urandom)};
    exp  = {4'h0, m_regs[m_cmd]};
    got  = 16'h0000;
    @(posedge clk);
    #1 ss_n = 1'b0; mosi = word[15];
    if (snap_wr) begin
      @(posedge clk);
      @(posedge clk);
      #1 wr_en = 1'b1; wr_ch = wch; wr_data = wval;
      @(posedge clk);
      #1 wr_en = 1'b0;
      m_regs[wch] = wval;
      repeat (HALF - 3) @(posedge clk);
    end else begin
      repeat (HALF) @(posedge clk);
    end
    for (int i = 0; i < nrise; i++) begin
      #1 sclk = 1'b0;
      if (i > 0) mosi = word[15-i];
      repeat (HALF) @(posedge clk);
      #1 got[15-i] = miso;
      sclk = 1'b1;
      if (i == mid_at) begin
        @(posedge clk);
        #1 wr_en = 1'b1; wr_ch = wch; wr_data = wval;
        @(posedge clk);
        #1 wr_en = 1'b0;
        m_regs[wch] = wval;
        repeat (HALF - 2) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
    end
    #1 ss_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fdv[k] = fd;
    end
    complete = (nrise == 16);
    check("miso_word", 32'(got >> (16 - nrise)), 32'(exp >> (16 - nrise)));
    check("frame_done_window", 32'(fdv), complete ? 32'h08 : 32'h00);
    if (complete) begin
      m_cmd = ch;
      fd_exp++;
    end
    check("cmd_chnnl", 32'(cmd), 32'(m_cmd));
    repeat (4 * HALF) @(posedge clk);
    #1 check("miso_idle", 32'(miso), 32'h0);
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] word;
    model_reset();

    #1;
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_frame_done", 32'(fd), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Directed table: basic response order and pot-scan sequence.
    tbl[0] = '{3'd3, 1'b0, 3'd0, 12'h000, 16'h0000};
    tbl[1] = '{3'd7, 1'b1, 3'd3, 12'hA5C, 16'h0A5C};
    tbl[2] = '{3'd0, 1'b1, 3'd7, 12'h3C7, 16'h03C7};
    tbl[3] = '{3'd0, 1'b1, 3'd0, 12'h111, 16'h0111};
    tbl[4] = '{3'd1, 1'b1, 3'd1, 12'h222, 16'h0111};
    tbl[5] = '{3'd2, 1'b1, 3'd2, 12'h333, 16'h0222};
    tbl[6] = '{3'd3, 1'b1, 3'd3, 12'h444, 16'h0333};
    tbl[7] = '{3'd4, 1'b1, 3'd4, 12'h555, 16'h0444};
    tbl[8] = '{3'd7, 1'b1, 3'd7, 12'h777, 16'h0555};
    tbl[9] = '{3'd0, 1'b0, 3'd0, 12'h000, 16'h0777};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].pre_wr) hwrite(tbl[i].wch, tbl[i].wval);
      frame(tbl[i].ch, 16, -1, 3'd0, 12'h000, 1'b0, got);
      check("tbl_word", 32'(got), 32'(tbl[i].exp_word));
      check("tbl_cmd", 32'(cmd), 32'(tbl[i].ch));
    end

    // Write to the channel being returned, mid-frame.
    frame(3'd2, 16, -1, 3'd0, 12'h000, 1'b0, got);
    check("pre_mid_word", 32'(got), 32'h0111);
    frame(3'd5, 16, 8, 3'd2, 12'hFFF, 1'b0, got);
    check("mid_write_old", 32'(got), 32'h0333);
    frame(3'd2, 16, -1, 3'd0, 12'h000, 1'b0, got);
    frame(3'd0, 16, -1, 3'd0, 12'h000, 1'b0, got);
    check("mid_write_new", 32'(got), 32'h0FFF);

    // Write landing on the same clock as the select snapshot.
    frame(3'd1, 16, -1, 3'd0, 12'hBEE, 1'b1, got);
    check("snap_old", 32'(got), 32'h0111);
    frame(3'd0, 16, -1, 3'd0, 12'h000, 1'b0, got);
    frame(3'd6, 16, -1, 3'd0, 12'h000, 1'b0, got);
    check("snap_new", 32'(got), 32'h0BEE);

    // Abort after 9 rising edges, then a full frame.
    frame(3'd5, 9, -1, 3'd0, 12'h000, 1'b0, got);
    check("abort_cmd", 32'(cmd), 32'h6);
    frame(3'd4, 16, -1, 3'd0, 12'h000, 1'b0, got);

    // Randomized frames against the reference model.
    for (int n = 0; n < 25; n++) begin
      int npre;
      int nr;
      int mid;
      npre = $urandom_range(0, 2);
      for (int p = 0; p < npre; p++) hwrite(3'($urandom), 12'($urandom));
      nr  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16;
      mid = ($urandom_range(0, 1) == 0) ? $urandom_range(0, nr - 1) : -1;
      frame(3'($urandom), nr, mid, 3'($urandom), 12'($urandom), bit'($urandom_range(0, 1)), got);
    end

    // Reset in the middle of a frame.
    frame(3'd5, 16, -1, 3'd0, 12'h000, 1'b0, got);
    hwrite(3'd0, 12'hABC);
    hwrite(3'd5, 12'h5A5);
    word = {2'b00, 3'd2, 11'h000};
    @(posedge clk);
    #1 ss_n = 1'b0; mosi = word[15];
    repeat (HALF) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      #1 sclk = 1'b0;
      if (i > 0) mosi = word[15-i];
      repeat (HALF) @(posedge clk);
      #1 sclk = 1'b1;
      repeat (HALF) @(posedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    check("midrst_miso", 32'(miso), 32'h0);
    check("midrst_cmd", 32'(cmd), 32'h0);
    ss_n = 1'b1;
    sclk = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    frame(3'd5, 16, -1, 3'd0, 12'h000, 1'b0, got);
    check("post_rst_ch0", 32'(got), 32'h0000);
    frame(3'd0, 16, -1, 3'd0, 12'h000, 1'b0, got);
    check("post_rst_ch5", 32'(got), 32'h0000);

    check("frame_done_total", 32'(fd_seen), 32'(fd_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
